// File: rtl/btn_conditioner_pkg.sv
// btn_conditioner shared types and clock-derived defaults.
// Optional auto-repeat is enabled by defining BTN_REPEAT_EN.
package btn_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } btn_state_t;

  localparam int unsigned CLK_HZ = 100_000_000;

  localparam int unsigned DEF_DEBOUNCE =
    CLK_HZ / 100;
  localparam int unsigned DEF_REPEAT_DELAY =
    CLK_HZ / 2;
  localparam int unsigned DEF_REPEAT_PERIOD =
    CLK_HZ / 10;

  function automatic int unsigned max2(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, debounce FSM, optional repeat.
// Auto-repeat logic exists only when BTN_REPEAT_EN is defined.
module btn_debounce_ch
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic oriclk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_END =
    CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  always_ff @(posedge oriclk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  btn_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_d;
  logic          press_d;
  logic          rel_d;
  logic          rpt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level;
    press_d = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      IDLE_LO: begin
        if (s) begin
          state_d = CHK_HI;
          cnt_d   = CNT_ONE;
        end
      end
      CHK_HI: begin
        if (!s) begin
          state_d = IDLE_LO;
        end else if (cnt_q == CNT_END) begin
          state_d = IDLE_HI;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (!s) begin
          state_d = CHK_LO;
          cnt_d   = CNT_ONE;
        end
      end
      CHK_LO: begin
        if (s) begin
          state_d = IDLE_HI;
        end else if (cnt_q == CNT_END) begin
          state_d = IDLE_LO;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge oriclk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
      rel     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level   <= level_d;
      press   <= press_d | rpt;
      rel     <= rel_d;
    end
  end

`ifdef BTN_REPEAT_EN
  localparam int RW =
    $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [RW-1:0] R_ONE   = RW'(1);
  localparam logic [RW-1:0] R_DELAY = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] R_PER   = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          rfirst_q, rfirst_d;

  // Counts only while held in IDLE_HI; any exit restarts the delay.
  always_comb begin
    rcnt_d   = '0;
    rfirst_d = 1'b1;
    rpt      = 1'b0;
    if (state_q == IDLE_HI && s) begin
      rfirst_d = rfirst_q;
      if (rcnt_q == (rfirst_q ? R_DELAY : R_PER)) begin
        rpt      = 1'b1;
        rfirst_d = 1'b0;
      end else begin
        rcnt_d = rcnt_q + R_ONE;
      end
    end
  end

  always_ff @(posedge oriclk or negedge rst) begin
    if (!rst) begin
      rcnt_q   <= '0;
      rfirst_q <= 1'b1;
    end else begin
      rcnt_q   <= rcnt_d;
      rfirst_q <= rfirst_d;
    end
  end
`else
  // Repeat parameters stay in the interface but drive nothing.
  assign rpt = 1'b0 & (REPEAT_DELAY > REPEAT_PERIOD);
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: level, press, release.
// Define BTN_REPEAT_EN to add auto-repeat press strobes.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned N_CH            = 2,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic            oriclk,
  input  logic            rst,
  input  logic [N_CH-1:0] raw,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  // release strobe; "release" is a reserved word
  output logic [N_CH-1:0] rel
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .oriclk(oriclk),
      .rst   (rst),
      .raw   (raw[i]),
      .level (level[i]),
      .press (press[i]),
      .rel   (rel[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with a run-length reference model.
// Honours BTN_REPEAT_EN for the auto-repeat hold scenario.
module tb_btn_conditioner;

  localparam int N  = 2;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic         oriclk = 1'b0;
  logic         rst    = 1'b0;
  logic [N-1:0] raw    = '0;
  logic [N-1:0] level;
  logic [N-1:0] press;
  logic [N-1:0] rel;

  btn_conditioner #(
    .N_CH           (N),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .oriclk(oriclk),
    .rst   (rst),
    .raw   (raw),
    .level (level),
    .press (press),
    .rel   (rel)
  );

  always #5 oriclk = ~oriclk;

  typedef struct {
    int           cyc;
    logic [N-1:0] lvl;
    logic [N-1:0] p;
    logic [N-1:0] r;
  } ev_t;

  ev_t q[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  bit           hist [N][SS];
  logic [N-1:0] m_lvl = '0;
  int           run  [N];
  int           t    [N];

  int npress [N];
  int nrel   [N];
  int lp_cyc [N];
  int lr_cyc [N];

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < SS; k++) hist[i][k] = 1'b0;
      run[i] = 0;
      t[i]   = 0;
    end
    m_lvl = '0;
  endtask

  always @(negedge rst) model_clear();

  // Level flips after DB consecutive sync samples that disagree with it.
  always @(posedge oriclk) begin : model
    logic [N-1:0] p, r;
    bit s;
    cyc = cyc + 1;
    p = '0;
    r = '0;
    if (!rst) begin
      model_clear();
    end else begin
      for (int i = 0; i < N; i++) begin
        s = hist[i][SS-1];
        for (int k = SS-1; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = raw[i];
        if (s != m_lvl[i]) begin
          run[i] = run[i] + 1;
          t[i]   = 0;
          if (run[i] == DB) begin
            m_lvl[i] = s;
            run[i]   = 0;
            if (s) p[i] = 1'b1;
            else   r[i] = 1'b1;
          end
        end else begin
          if (m_lvl[i] && run[i] == 0) begin
            t[i] = t[i] + 1;
`ifdef BTN_REPEAT_EN
            if (t[i] == RD || (t[i] > RD && (t[i] - RD) % RP == 0))
              p[i] = 1'b1;
`endif
          end else begin
            t[i] = 0;
          end
          run[i] = 0;
        end
      end
      if ((p | r) != '0) q.push_back('{cyc, m_lvl, p, r});
    end
  end

  always @(negedge oriclk) begin : monitor
    ev_t e;
    tests = tests + 1;
    if (level !== m_lvl) begin
      fails = fails + 1;
      $display("FAIL level cyc=%0d got=%b want=%b",
               cyc, level, m_lvl);
    end
    if ((press & rel) != '0) begin
      fails = fails + 1;
      $display("FAIL exclusive cyc=%0d press=%b rel=%b",
               cyc, press, rel);
    end
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      fails = fails + 1;
      $display("FAIL missing cyc=%0d got=none want p=%b r=%b",
               e.cyc, e.p, e.r);
    end
    if ((|(press | rel)) !== 1'b0) begin
      tests = tests + 1;
      if (q.size() == 0 || q[0].cyc != cyc) begin
        fails = fails + 1;
        $display("FAIL unexpected cyc=%0d got p=%b r=%b want none",
                 cyc, press, rel);
      end else begin
        e = q.pop_front();
        if (press !== e.p || rel !== e.r) begin
          fails = fails + 1;
          $display("FAIL strobe cyc=%0d got p=%b r=%b want p=%b r=%b",
                   cyc, press, rel, e.p, e.r);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (press[i] === 1'b1) begin
          npress[i] = npress[i] + 1;
          lp_cyc[i] = cyc;
        end
        if (rel[i] === 1'b1) begin
          nrel[i]   = nrel[i] + 1;
          lr_cyc[i] = cyc;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests = tests + 1;
    if (act != exp) begin
      fails = fails + 1;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] v, output int d);
    @(posedge oriclk);
    #2;
    raw = v;
    d   = cyc;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge oriclk);
  endtask

  int d, p0, p1, r0, n0;
  int hold [N];

  initial begin
    for (int i = 0; i < N; i++) begin
      npress[i] = 0;
      nrel[i]   = 0;
      lp_cyc[i] = -1;
      lr_cyc[i] = -1;
      hold[i]   = 1;
    end
    cycles(3);
    #2;
    rst = 1'b1;
    cycles(4);

    p0 = npress[0];
    p1 = npress[1];
    drive(2'b01, d);
    cycles(10);
    check("clean_press_cyc", lp_cyc[0], d + SS + DB);
    check("clean_press_cnt", npress[0] - p0, 1);
    check("clean_ch1_silent", npress[1] - p1, 0);

    p0 = npress[0];
    r0 = nrel[0];
    drive(2'b00, d);
    cycles(10);
    check("release_cyc", lr_cyc[0], d + SS + DB);
    check("release_cnt", nrel[0] - r0, 1);
    check("release_no_press", npress[0] - p0, 0);

    p0 = npress[0];
    drive(2'b01, d);
    cycles(1);
    drive(2'b00, d);
    cycles(1);
    drive(2'b01, d);
    cycles(1);
    drive(2'b00, d);
    cycles(1);
    drive(2'b01, d);
    cycles(12);
    check("bounce_press_cnt", npress[0] - p0, 1);
    check("bounce_press_cyc", lp_cyc[0], d + SS + DB);

    drive(2'b00, d);
    cycles(10);
    p0 = npress[0];
    p1 = npress[1];
    drive(2'b11, d);
    cycles(10);
    check("simul_ch0_cyc", lp_cyc[0], d + SS + DB);
    check("simul_ch1_cyc", lp_cyc[1], d + SS + DB);
    check("simul_cnt", (npress[0] - p0) + (npress[1] - p1), 2);
    check("simul_level", int'(level), 3);

    drive(2'b00, d);
    cycles(10);
    p0 = npress[0];
    drive(2'b01, d);
    cycles(3);
    #2;
    rst = 1'b0;
    cycles(4);
    check("reset_no_press", npress[0] - p0, 0);
    check("reset_level", int'(level), 0);
    #2;
    rst = 1'b1;
    d   = cyc;
    cycles(10);
    check("reset_press_cyc", lp_cyc[0], d + SS + DB);
    check("reset_press_cnt", npress[0] - p0, 1);

    drive(2'b00, d);
    cycles(10);

`ifdef BTN_REPEAT_EN
    p0 = npress[0];
    r0 = nrel[0];
    drive(2'b01, d);
    cycles(SS + DB + 30);
    check("repeat_press_cnt", npress[0] - p0, 8);
    check("repeat_no_release", nrel[0] - r0, 0);
    drive(2'b00, d);
    cycles(12);
    check("repeat_release_cnt", nrel[0] - r0, 1);
`endif

    n0 = npress[0] + nrel[0] + npress[1] + nrel[1];
    for (int c = 0; c < 800; c++) begin
      @(posedge oriclk);
      #2;
      for (int i = 0; i < N; i++) begin
        hold[i] = hold[i] - 1;
        if (hold[i] == 0) begin
          raw[i]  = ~raw[i];
          hold[i] = $urandom_range(1, 8);
        end
      end
    end
    raw = '0;
    cycles(20);
    tests = tests + 1;
    if (npress[0] + nrel[0] + npress[1] + nrel[1] == n0) begin
      fails = fails + 1;
      $display("FAIL random_activity got=0 strobes want=nonzero");
    end
    check("queue_drained", q.size(), 0);
    check("final_level", int'(level), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
Parametrised multi-channel input conditioner for the game's push-button inputs (flap "up", mode/start "btn", and future buttons).
- Per channel: synchronises the raw asynchronous pin into the oriclk domain, then debounces it with a per-channel state machine.
- Outputs a clean level plus single-cycle press and release strobes.
- Sits between the top-level pins and the game-control logic, replacing per-button ad-hoc edge detection.

Parameters:
- N_CH, 2, number of independent button channels.
- SYNC_STAGES, 2, synchroniser flip-flop depth (legal values >= 2).
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a new level (10 ms at 100 MHz; legal values >= 2).
- REPEAT_DELAY, 50000000, cycles a press must be held before the first auto-repeat strobe (used only with BTN_REPEAT_EN).
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat strobes (used only with BTN_REPEAT_EN).

Ports:
- oriclk  input  1  system clock, single clock domain.
- rst  input  1  asynchronous, active-low reset.
- raw  input  N_CH  unsynchronised button pins; bit i = channel i.
- level  output  N_CH  debounced button state.
- press  output  N_CH  one-cycle strobe on an accepted 0->1 transition (and on auto-repeat when enabled).
- release  output  N_CH  one-cycle strobe on an accepted 1->0 transition.

Behaviour:
- Reset: rst low asynchronously clears the synchroniser chains, counters, state (IDLE_LO), level, press and release.
  - Reset mid-debounce discards the count.
  - No strobe is emitted on reset entry or exit.
- Synchroniser: SYNC_STAGES flops per channel, reset value 0. Its output is s[i].
- Per-channel FSM states and transitions:
  - IDLE_LO: if s=1, go to CHK_HI and set cnt=1.
  - CHK_HI:
    - s=0: go to IDLE_LO (bounce rejected, no strobe).
    - s=1 and cnt==DEBOUNCE_CYCLES-1: go to IDLE_HI; level<=1; press<=1 for one cycle.
    - Otherwise: cnt++.
  - IDLE_HI: if s=0, go to CHK_LO and set cnt=1.
  - CHK_LO: mirror of CHK_HI. Rejects a bounce back to IDLE_HI. On acceptance, level<=0 and release<=1 for one cycle.
- Latency: a raw step held stable is first sampled at clock edge E. press/release is then high during the cycle after edge E+SYNC_STAGES+DEBOUNCE_CYCLES-1.
  - That is SYNC_STAGES+DEBOUNCE_CYCLES cycles of latency.
  - With SYNC_STAGES=2 and DEBOUNCE_CYCLES=4, the strobe appears 6 cycles after the first sample.
- Counter width: $clog2(DEBOUNCE_CYCLES+1) bits. The counter never wraps because it stops at the terminal value.
- Channel independence: channels are fully independent. Simultaneous strobes on several channels are allowed and expected.
- Strobe exclusivity: press and release of the same channel are never high in the same cycle.
- Registered outputs: all outputs are registered, with no combinational path from raw.
- Glitches: a glitch shorter than DEBOUNCE_CYCLES never changes level.

Optional Feature:
- Macro: BTN_REPEAT_EN.
- Defined: each channel gets a repeat counter that runs while in IDLE_HI.
  - press re-pulses REPEAT_DELAY cycles after the accepted press, then every REPEAT_PERIOD cycles.
  - Leaving IDLE_HI clears the counter.
  - level is unaffected.
- Undefined: no repeat logic is synthesised. press fires exactly once per accepted press, and REPEAT_* parameters are ignored.

Decomposition:
- Shared package/include holds:
  - FSM state encodings: IDLE_LO=2'd0, CHK_HI=2'd1, IDLE_HI=2'd2, CHK_LO=2'd3.
  - The default clock frequency constant (100 MHz), from which DEBOUNCE_CYCLES defaults are derived.
- Sub-module: btn_debounce_ch, one channel containing the synchroniser, FSM and optional repeat logic.
  - btn_conditioner instantiates it N_CH times with a generate loop.

Test Plan (bench uses SYNC_STAGES=2, DEBOUNCE_CYCLES=4, N_CH=2; REPEAT_DELAY=10 and REPEAT_PERIOD=3 when BTN_REPEAT_EN is defined):
- Clean press: raw[0] 0->1 held -> press[0]=1 for exactly one cycle, 6 cycles after first sample. level[0]=1 from the same cycle. raw[1]=0 leaves channel 1 silent.
- Bounce rejection: raw[0] toggles 1,0,1,0 at 2-cycle intervals then settles at 1 -> exactly one press[0]. It occurs 6 cycles after the final rising sample.
- Release: after level[0]=1, drive raw[0]=0 -> release[0]=1 for one cycle after 6 cycles; level[0]=0; press[0] stays 0.
- Simultaneous channels: raw=2'b11 on the same edge -> press=2'b11 on the same cycle, level=2'b11.
- Reset mid-debounce: raw[0]=1, assert rst low after 3 cycles, release rst with raw[0] still 1 -> no strobe during reset. After release, press[0] fires 6 cycles later; level=0 throughout reset.
- BTN_REPEAT_EN hold: hold raw[0]=1 for 30 cycles after the accepted press -> press[0] at offsets 0, 10, 13, 16, …, 28; release[0] only after raw drops.
